// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ENDED = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int SEC_MAX = 59;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/bcd_field_counter.sv
// Two-digit BCD counter, modulo MAX+1, with a clear, a load, an increment and a borrow-chained decrement.
// Latency: q updates one cycle after the control strobe; borrow_out is combinational.
// Backpressure: none; every strobe is acted on in the cycle it is seen (clr > load > dec > inc).
module bcd_field_counter
    import timer_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       borrow_in,
    output logic       borrow_out,
    output logic [7:0] q
);

    localparam logic [7:0] MAX_BCD = to_bcd(MAX);

    bcd_t       lo;
    bcd_t       hi;
    logic [7:0] q_inc;
    logic [7:0] q_dec;

    assign lo = q[3:0];
    assign hi = q[7:4];

    // A field only steps down when every lower field is wrapping through zero.
    assign borrow_out = dec & borrow_in & (q == 8'h00);

    always_comb begin
        q_inc = {hi, lo + 4'd1};
        if (q == MAX_BCD) begin
            q_inc = 8'h00;
        end else if (lo == 4'd9) begin
            q_inc = {hi + 4'd1, 4'd0};
        end
    end

    always_comb begin
        q_dec = {hi, lo - 4'd1};
        if (q == 8'h00) begin
            q_dec = MAX_BCD;
        end else if (lo == 4'd0) begin
            q_dec = {hi - 4'd1, 4'd9};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 8'h00;
        end else if (clr) begin
            q <= 8'h00;
        end else if (load) begin
            q <= load_val;
        end else if (dec && borrow_in) begin
            q <= q_dec;
        end else if (inc) begin
            q <= q_inc;
        end
    end

endmodule

// File: rtl/countdown_timer_core.sv
// BCD countdown timer: edit while idle, count down at 1 Hz while running, blink the display once ended.
// Latency: all outputs registered; DIGITS change the cycle after the causing strobe or tick.
// Backpressure: none; strobes are single-cycle pulses resolved by fixed priority.
module countdown_timer_core
    import timer_pkg::*;
#(
    parameter int CLK_HZ      = 25_175_000,
    parameter int FIELDS      = 2,
    parameter int TOP_MAX     = 59,
    parameter int AUTO_RELOAD = 0,
    parameter int BLINK_DIV   = 2
) (
    input  logic                MCLK,
    input  logic                RST,
    input  logic                START_STOP,
    input  logic                CLEAR,
    input  logic                INC_SEC,
    input  logic                INC_MIN,
    input  logic                INC_HR,
    output logic [8*FIELDS-1:0] DIGITS,
    output logic                RUNNING,
    output logic                ENDED,
    output logic                DONE,
    output logic                BLINK,
    output logic                TICK
);

    localparam int DW   = 8 * FIELDS;
    localparam int PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int HALF = CLK_HZ / BLINK_DIV;
    localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

    state_t        state_q;
    state_t        state_d;
    logic [DW-1:0] preset_q;
    logic [PW-1:0] presc_q;
    logic [BW-1:0] blink_cnt_q;

    logic          clr_all;
    logic          load_all;
    logic          dec;
    logic          inc_en;
    logic          capture;
    logic          presc_clr;
    logic          done_d;
    logic          tick_d;
    logic          tick_now;
    logic          is_zero;
    logic          is_one;

    logic [2:0]    inc_all;
    logic [FIELDS:0] borrow;
    logic          unused_inc;
    logic          unused_borrow;

    assign inc_all       = {INC_HR, INC_MIN, INC_SEC};
    assign unused_inc    = inc_all[2];
    assign borrow[0]     = 1'b1;
    assign unused_borrow = borrow[FIELDS];

    genvar gi;
    generate
        for (gi = 0; gi < FIELDS; gi++) begin : g_field
            localparam int FMAX = (gi == FIELDS - 1) ? TOP_MAX : SEC_MAX;
            bcd_field_counter #(.MAX(FMAX)) u_field (
                .clk        (MCLK),
                .rst        (RST),
                .inc        (inc_en & inc_all[gi]),
                .dec        (dec),
                .clr        (clr_all),
                .load       (load_all),
                .load_val   (preset_q[8*gi +: 8]),
                .borrow_in  (borrow[gi]),
                .borrow_out (borrow[gi+1]),
                .q          (DIGITS[8*gi +: 8])
            );
        end
    endgenerate

    assign is_zero  = (DIGITS == '0);
    assign is_one   = (DIGITS == DW'(1));
    assign tick_now = (state_q == ST_RUN) && (presc_q == PW'(CLK_HZ - 1));

    always_comb begin
        state_d   = state_q;
        clr_all   = 1'b0;
        load_all  = 1'b0;
        dec       = 1'b0;
        inc_en    = 1'b0;
        capture   = 1'b0;
        presc_clr = 1'b0;
        done_d    = 1'b0;
        tick_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (CLEAR) begin
                    clr_all = 1'b1;
                end else if (START_STOP) begin
                    if (!is_zero) begin
                        state_d   = ST_RUN;
                        capture   = 1'b1;
                        presc_clr = 1'b1;
                    end
                end else begin
                    inc_en = 1'b1;
                end
            end
            ST_RUN: begin
                // A pause landing on the tick cycle swallows that tick.
                if (START_STOP) begin
                    state_d = ST_IDLE;
                end else if (tick_now) begin
                    dec    = 1'b1;
                    tick_d = 1'b1;
                    if (is_one) begin
                        state_d = ST_ENDED;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_ENDED: begin
                if (CLEAR) begin
                    state_d = ST_IDLE;
                    clr_all = 1'b1;
                end else if (START_STOP) begin
                    state_d = ST_IDLE;
                    if (AUTO_RELOAD != 0) begin
                        load_all = 1'b1;
                    end else begin
                        clr_all = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            preset_q <= '0;
        end else if (capture) begin
            preset_q <= DIGITS;
        end
    end

    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            presc_q <= '0;
        end else if (presc_clr || tick_now) begin
            presc_q <= '0;
        end else if (state_q == ST_RUN) begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // Blink phase restarts dark on every entry to ENDED.
    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            blink_cnt_q <= '0;
            BLINK       <= 1'b1;
        end else if (state_d == ST_ENDED && state_q != ST_ENDED) begin
            blink_cnt_q <= '0;
            BLINK       <= 1'b0;
        end else if (state_d == ST_ENDED) begin
            if (blink_cnt_q == BW'(HALF - 1)) begin
                blink_cnt_q <= '0;
                BLINK       <= ~BLINK;
            end else begin
                blink_cnt_q <= blink_cnt_q + BW'(1);
            end
        end else begin
            blink_cnt_q <= '0;
            BLINK       <= 1'b1;
        end
    end

    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            RUNNING <= 1'b0;
            ENDED   <= 1'b0;
            DONE    <= 1'b0;
            TICK    <= 1'b0;
        end else begin
            RUNNING <= (state_d == ST_RUN);
            ENDED   <= (state_d == ST_ENDED);
            DONE    <= done_d;
            TICK    <= tick_d;
        end
    end

endmodule

// File: tb/tb_countdown_timer_core.sv
// Directed bench: an MM:SS instance without reload and an HH:MM:SS instance with reload, CLK_HZ=10.
module tb_countdown_timer_core;

    localparam logic [4:0] SS  = 5'b00001;
    localparam logic [4:0] CLR = 5'b00010;
    localparam logic [4:0] SEC = 5'b00100;
    localparam logic [4:0] MIN = 5'b01000;
    localparam logic [4:0] HR  = 5'b10000;

    logic        mclk = 1'b0;
    logic        rst  = 1'b1;
    logic        ss_a = 0, clr_a = 0, sec_a = 0, min_a = 0, hr_a = 0;
    logic        ss_b = 0, clr_b = 0, sec_b = 0, min_b = 0, hr_b = 0;
    logic [15:0] dig_a;
    logic [23:0] dig_b;
    logic        run_a, end_a, done_a, blink_a, tick_a;
    logic        run_b, end_b, done_b, blink_b, tick_b;

    int checks = 0;
    int passed = 0;

    always #5 mclk = ~mclk;

    countdown_timer_core #(
        .CLK_HZ(10), .FIELDS(2), .TOP_MAX(59), .AUTO_RELOAD(0), .BLINK_DIV(2)
    ) dut_a (
        .MCLK(mclk), .RST(rst), .START_STOP(ss_a), .CLEAR(clr_a),
        .INC_SEC(sec_a), .INC_MIN(min_a), .INC_HR(hr_a),
        .DIGITS(dig_a), .RUNNING(run_a), .ENDED(end_a), .DONE(done_a),
        .BLINK(blink_a), .TICK(tick_a)
    );

    countdown_timer_core #(
        .CLK_HZ(10), .FIELDS(3), .TOP_MAX(23), .AUTO_RELOAD(1), .BLINK_DIV(2)
    ) dut_b (
        .MCLK(mclk), .RST(rst), .START_STOP(ss_b), .CLEAR(clr_b),
        .INC_SEC(sec_b), .INC_MIN(min_b), .INC_HR(hr_b),
        .DIGITS(dig_b), .RUNNING(run_b), .ENDED(end_b), .DONE(done_b),
        .BLINK(blink_b), .TICK(tick_b)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    // Drive a one-cycle strobe set; returns #1 after the edge that sampled it.
    task automatic pulse_a(input logic [4:0] m);
        {hr_a, min_a, sec_a, clr_a, ss_a} = m;
        @(posedge mclk);
        #1;
        {hr_a, min_a, sec_a, clr_a, ss_a} = 5'b0;
    endtask

    task automatic pulse_b(input logic [4:0] m);
        {hr_b, min_b, sec_b, clr_b, ss_b} = m;
        @(posedge mclk);
        #1;
        {hr_b, min_b, sec_b, clr_b, ss_b} = 5'b0;
    endtask

    task automatic test_reset;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        checks++; if (dig_a !== 16'h0000) $display("FAIL reset_digits_a got=%h exp=0000", dig_a); else passed++;
        checks++; if (dig_b !== 24'h000000) $display("FAIL reset_digits_b got=%h exp=000000", dig_b); else passed++;
        checks++; if ({run_a, end_a, done_a, tick_a, blink_a} !== 5'b00001)
            $display("FAIL reset_status got=%b exp=00001", {run_a, end_a, done_a, tick_a, blink_a}); else passed++;
    endtask

    task automatic test_inc_wrap;
        for (int i = 0; i < 61; i++) pulse_a(SEC);
        checks++; if (dig_a !== 16'h0001) $display("FAIL sec_wrap got=%h exp=0001", dig_a); else passed++;
        for (int i = 0; i < 60; i++) pulse_a(MIN);
        checks++; if (dig_a !== 16'h0001) $display("FAIL min_wrap got=%h exp=0001", dig_a); else passed++;
        pulse_a(CLR);
        checks++; if (dig_a !== 16'h0000) $display("FAIL idle_clear got=%h exp=0000", dig_a); else passed++;
    endtask

    task automatic test_countdown_end;
        pulse_a(MIN);
        checks++; if (dig_a !== 16'h0100) $display("FAIL load_0100 got=%h exp=0100", dig_a); else passed++;
        pulse_a(SS);
        checks++; if (run_a !== 1'b1) $display("FAIL start_running got=%b exp=1", run_a); else passed++;
        cyc(9);
        checks++; if ({dig_a, tick_a} !== {16'h0100, 1'b0})
            $display("FAIL pre_tick got=%h/%b exp=0100/0", dig_a, tick_a); else passed++;
        cyc(1);
        checks++; if ({dig_a, tick_a} !== {16'h0059, 1'b1})
            $display("FAIL first_tick got=%h/%b exp=0059/1", dig_a, tick_a); else passed++;
        cyc(1);
        checks++; if (tick_a !== 1'b0) $display("FAIL tick_single got=%b exp=0", tick_a); else passed++;
        cyc(299);
        checks++; if (dig_a !== 16'h0029) $display("FAIL mid_count got=%h exp=0029", dig_a); else passed++;
        cyc(289);
        checks++; if ({dig_a, run_a, done_a} !== {16'h0001, 1'b1, 1'b0})
            $display("FAIL last_second got=%h/%b/%b exp=0001/1/0", dig_a, run_a, done_a); else passed++;
        cyc(1);
        checks++; if ({dig_a, run_a, end_a, done_a, blink_a} !== {16'h0000, 4'b0110})
            $display("FAIL end_entry got=%h/%b exp=0000/0110", dig_a, {run_a, end_a, done_a, blink_a}); else passed++;
        cyc(1);
        checks++; if ({done_a, blink_a} !== 2'b00) $display("FAIL done_single got=%b exp=00", {done_a, blink_a}); else passed++;
        cyc(3);
        checks++; if (blink_a !== 1'b0) $display("FAIL blink_dark_end got=%b exp=0", blink_a); else passed++;
        cyc(1);
        checks++; if (blink_a !== 1'b1) $display("FAIL blink_on got=%b exp=1", blink_a); else passed++;
        cyc(4);
        checks++; if (blink_a !== 1'b1) $display("FAIL blink_on_end got=%b exp=1", blink_a); else passed++;
        cyc(1);
        checks++; if (blink_a !== 1'b0) $display("FAIL blink_off got=%b exp=0", blink_a); else passed++;
        pulse_a(SS);
        checks++; if ({dig_a, end_a, run_a, blink_a} !== {16'h0000, 3'b001})
            $display("FAIL exit_no_reload got=%h/%b exp=0000/001", dig_a, {end_a, run_a, blink_a}); else passed++;
    endtask

    task automatic test_pause_on_tick;
        for (int i = 0; i < 10; i++) pulse_a(SEC);
        checks++; if (dig_a !== 16'h0010) $display("FAIL load_0010 got=%h exp=0010", dig_a); else passed++;
        pulse_a(SS);
        cyc(9);
        pulse_a(SS);
        checks++; if ({dig_a, run_a, tick_a} !== {16'h0010, 2'b00})
            $display("FAIL pause_on_tick got=%h/%b exp=0010/00", dig_a, {run_a, tick_a}); else passed++;
        pulse_a(SS);
        cyc(9);
        checks++; if (dig_a !== 16'h0010) $display("FAIL restart_hold got=%h exp=0010", dig_a); else passed++;
        cyc(1);
        checks++; if (dig_a !== 16'h0009) $display("FAIL restart_tick got=%h exp=0009", dig_a); else passed++;
        pulse_a(SS);
        pulse_a(CLR);
    endtask

    task automatic test_ignored;
        pulse_a(SS);
        checks++; if (run_a !== 1'b0) $display("FAIL start_at_zero got=%b exp=0", run_a); else passed++;
        for (int i = 0; i < 3; i++) pulse_a(SEC);
        pulse_a(SS);
        pulse_a(SEC);
        checks++; if ({dig_a, run_a} !== {16'h0003, 1'b1})
            $display("FAIL inc_in_run got=%h/%b exp=0003/1", dig_a, run_a); else passed++;
        pulse_a(SS);
        pulse_a(CLR);
        checks++; if ({dig_a, run_a} !== {16'h0000, 1'b0})
            $display("FAIL pause_clear got=%h/%b exp=0000/0", dig_a, run_a); else passed++;
    endtask

    task automatic test_fields3;
        pulse_b(HR);
        checks++; if (dig_b !== 24'h010000) $display("FAIL load_010000 got=%h exp=010000", dig_b); else passed++;
        pulse_b(SS);
        cyc(10);
        checks++; if ({dig_b, tick_b} !== {24'h005959, 1'b1})
            $display("FAIL hms_borrow got=%h/%b exp=005959/1", dig_b, tick_b); else passed++;
        pulse_b(SS);
        pulse_b(CLR);
        for (int i = 0; i < 23; i++) pulse_b(HR);
        checks++; if (dig_b !== 24'h230000) $display("FAIL hr_max got=%h exp=230000", dig_b); else passed++;
        pulse_b(HR);
        checks++; if (dig_b !== 24'h000000) $display("FAIL hr_wrap got=%h exp=000000", dig_b); else passed++;
    endtask

    task automatic test_auto_reload;
        pulse_b(MIN | SEC);
        checks++; if (dig_b !== 24'h000101) $display("FAIL multi_inc got=%h exp=000101", dig_b); else passed++;
        pulse_b(MIN);
        for (int i = 0; i < 4; i++) pulse_b(SEC);
        checks++; if (dig_b !== 24'h000205) $display("FAIL load_0205 got=%h exp=000205", dig_b); else passed++;
        pulse_b(SS);
        cyc(1249);
        checks++; if (dig_b !== 24'h000001) $display("FAIL reload_last got=%h exp=000001", dig_b); else passed++;
        cyc(1);
        checks++; if ({dig_b, end_b, done_b} !== {24'h000000, 2'b11})
            $display("FAIL reload_end got=%h/%b exp=000000/11", dig_b, {end_b, done_b}); else passed++;
        pulse_b(SS);
        checks++; if ({dig_b, end_b, run_b} !== {24'h000205, 2'b00})
            $display("FAIL reload_exit got=%h/%b exp=000205/00", dig_b, {end_b, run_b}); else passed++;
        pulse_b(SS);
        cyc(1250);
        checks++; if (end_b !== 1'b1) $display("FAIL reload_end2 got=%b exp=1", end_b); else passed++;
        pulse_b(CLR);
        checks++; if ({dig_b, end_b, blink_b} !== {24'h000000, 2'b01})
            $display("FAIL clear_in_ended got=%h/%b exp=000000/01", dig_b, {end_b, blink_b}); else passed++;
    endtask

    task automatic test_reset_mid_run;
        pulse_a(MIN);
        for (int i = 0; i < 30; i++) pulse_a(SEC);
        pulse_a(SS);
        cyc(25);
        checks++; if ({dig_a, run_a} !== {16'h0128, 1'b1})
            $display("FAIL run_0128 got=%h/%b exp=0128/1", dig_a, run_a); else passed++;
        rst = 1'b1;
        cyc(1);
        checks++; if ({dig_a, run_a, end_a, blink_a} !== {16'h0000, 3'b001})
            $display("FAIL reset_mid_run got=%h/%b exp=0000/001", dig_a, {run_a, end_a, blink_a}); else passed++;
        rst = 1'b0;
        cyc(12);
        checks++; if ({dig_a, run_a} !== {16'h0000, 1'b0})
            $display("FAIL post_reset_idle got=%h/%b exp=0000/0", dig_a, run_a); else passed++;
    endtask

    initial begin
        test_reset;
        test_inc_wrap;
        test_countdown_end;
        test_pause_on_tick;
        test_ignored;
        test_fields3;
        test_auto_reload;
        test_reset_mid_run;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
